// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, EXC} state_t;

  localparam int MAX_W = 64;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  // Most negative two's-complement value for a w-bit word, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] min_val(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction
endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - operand/result bundle between multdiv controller and divider
interface div_seq_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_DIV;
  logic             ctrl_SIGNED;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output data_operandA, data_operandB, ctrl_DIV, ctrl_SIGNED,
    input  data_result, data_remainder, data_exception, data_resultRDY, data_busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_DIV, ctrl_SIGNED,
    output data_result, data_remainder, data_exception, data_resultRDY, data_busy
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d};

  // Partial remainder stays below d, so a set top bit of the trial means borrow.
  always_comb begin
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative signed/unsigned restoring divider with exception detection
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  div_seq_if.slave   bus
);
  localparam int               CNT_W   = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_val(WIDTH));

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo, neg_rem, ovf;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn   = SIGNED_EN & bus.ctrl_SIGNED;
  assign a_neg = sgn & bus.data_operandA[WIDTH-1];
  assign b_neg = sgn & bus.data_operandB[WIDTH-1];
  assign a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (rem_q),
    .q      (quo_q),
    .d      (dvs_q),
    .r_next (rem_nx),
    .q_next (quo_nx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      rem_q              <= '0;
      quo_q              <= '0;
      dvs_q              <= '0;
      neg_quo            <= 1'b0;
      neg_rem            <= 1'b0;
      ovf                <= 1'b0;
      bus.data_result    <= '0;
      bus.data_remainder <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.data_busy      <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_DIV) begin
            bus.data_busy <= 1'b1;
            if (bus.data_operandB == '0) begin
              state <= EXC;
              ovf   <= 1'b0;
              quo_q <= bus.data_operandA;
            end else if (sgn && bus.data_operandA == MIN_VAL && bus.data_operandB == '1) begin
              state <= EXC;
              ovf   <= 1'b1;
            end else begin
              state   <= RUN;
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvs_q   <= b_mag;
              cnt     <= CNT_W'(WIDTH);
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
            end
          end
        end
        RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          bus.data_result    <= neg_quo ? -quo_q : quo_q;
          bus.data_remainder <= neg_rem ? -rem_q : rem_q;
          bus.data_exception <= 1'b0;
          bus.data_resultRDY <= 1'b1;
          bus.data_busy      <= 1'b0;
          state              <= IDLE;
        end
        EXC: begin
          // quo_q still holds the raw dividend for the divide-by-zero case.
          bus.data_result    <= ovf ? MIN_VAL : '0;
          bus.data_remainder <= ovf ? '0 : quo_q;
          bus.data_exception <= 1'b1;
          bus.data_resultRDY <= 1'b1;
          bus.data_busy      <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed and randomised checks of div_seq at WIDTH 32 and 8
module tb_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) if32();
  div_seq_if #(.WIDTH(8))  if8();

  div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (.clock(clk), .reset_n(rst_n), .bus(if32.slave));
  div_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) u8  (.clock(clk), .reset_n(rst_n), .bus(if8.slave));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input bit go);
    if (w8) begin
      if8.data_operandA = a[7:0];
      if8.data_operandB = b[7:0];
      if8.ctrl_SIGNED   = s;
      if8.ctrl_DIV      = go;
    end else begin
      if32.data_operandA = a;
      if32.data_operandB = b;
      if32.ctrl_SIGNED   = s;
      if32.ctrl_DIV      = go;
    end
  endtask

  function automatic logic rdy_of(input bit w8);
    return w8 ? if8.data_resultRDY : if32.data_resultRDY;
  endfunction

  function automatic logic busy_of(input bit w8);
    return w8 ? if8.data_busy : if32.data_busy;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s);
    drive(w8, a, b, s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(w8, a, b, s, 1'b0);
  endtask

  task automatic wait_rdy(input bit w8, output int lat);
    lat = 0;
    while (!rdy_of(w8) && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic op(input string tag, input bit w8, input logic [31:0] a, input logic [31:0] b,
                    input bit s, input logic [31:0] e_res, input logic [31:0] e_rem,
                    input logic e_exc, input int e_lat);
    int lat;
    start(w8, a, b, s);
    chk({tag, ".busy_run"}, 32'(busy_of(w8)), 32'd1);
    wait_rdy(w8, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    if (w8) begin
      chk({tag, ".res"}, {24'd0, if8.data_result}, e_res);
      chk({tag, ".rem"}, {24'd0, if8.data_remainder}, e_rem);
      chk({tag, ".exc"}, 32'(if8.data_exception), 32'(e_exc));
    end else begin
      chk({tag, ".res"}, if32.data_result, e_res);
      chk({tag, ".rem"}, if32.data_remainder, e_rem);
      chk({tag, ".exc"}, 32'(if32.data_exception), 32'(e_exc));
    end
    chk({tag, ".busy_rdy"}, 32'(busy_of(w8)), 32'd0);
  endtask

  task automatic gold8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    logic signed [7:0] as8, bs8;
    int sa, sb, iq, ir;
    as8 = a;
    bs8 = b;
    sa = as8;
    sb = bs8;
    e = 1'b0;
    if (b == 8'd0) begin
      q = 32'd0; r = {24'd0, a}; e = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q = 32'h80; r = 32'd0; e = 1'b1;
    end else if (s) begin
      iq = sa / sb;
      ir = sa % sb;
      q = {24'd0, iq[7:0]};
      r = {24'd0, ir[7:0]};
    end else begin
      q = {24'd0, a / b};
      r = {24'd0, a % b};
    end
  endtask

  initial begin
    int lat, seen;
    logic [31:0] gq, gr;
    logic ge;
    logic [7:0] ra, rb;
    bit rs;

    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset.res",  if32.data_result, 32'd0);
    chk("reset.rem",  if32.data_remainder, 32'd0);
    chk("reset.exc",  32'(if32.data_exception), 32'd0);
    chk("reset.rdy",  32'(if32.data_resultRDY), 32'd0);
    chk("reset.busy", 32'(if32.data_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op("t1_u100_7",  1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    op("t2_sm7_2",   1'b0, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    op("t2_s7_m2",   1'b0, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 33);
    op("t3_s5_0",    1'b0, 32'd5, 32'd0, 1'b1, 32'd0, 32'd5, 1'b1, 1);
    op("t3_u5_0",    1'b0, 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b1, 1);
    op("t4_s_ovf",   1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b1, 1);
    op("t4_u_min",   1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 33);

    // Re-request mid-run with different operands must be ignored.
    start(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    drive(1'b0, 32'd50, 32'd5, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
    chk("t5_ign.busy", 32'(if32.data_busy), 32'd1);
    wait_rdy(1'b0, lat);
    chk("t5_ign.lat", 32'(lat + 6), 32'd33);
    chk("t5_ign.res", if32.data_result, 32'd14);
    chk("t5_ign.rem", if32.data_remainder, 32'd2);

    // Reset asserted ahead of edge 10 aborts silently.
    start(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst.rdy",  32'(if32.data_resultRDY), 32'd0);
    chk("t5_rst.res",  if32.data_result, 32'd0);
    chk("t5_rst.rem",  if32.data_remainder, 32'd0);
    chk("t5_rst.exc",  32'(if32.data_exception), 32'd0);
    chk("t5_rst.busy", 32'(if32.data_busy), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (if32.data_resultRDY) seen++;
    end
    chk("t5_rst.no_rdy", 32'(seen), 32'd0);

    // WIDTH=8, second op started in the RDY cycle of the first.
    op("t6_u255_16", 1'b1, 32'd255, 32'd16, 1'b0, 32'd15, 32'd15, 1'b0, 9);
    op("t6_b2b",     1'b1, 32'd200, 32'd3,  1'b0, 32'd66, 32'd2,  1'b0, 9);
    op("t6_s_ovf",   1'b1, 32'h80, 32'hFF, 1'b1, 32'h80, 32'd0,  1'b1, 1);
    op("t6_u_min",   1'b1, 32'h80, 32'hFF, 1'b0, 32'd0,  32'h80, 1'b0, 9);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      gold8(ra, rb, rs, gq, gr, ge);
      op($sformatf("t6_rand%0d", i), 1'b1, {24'd0, ra}, {24'd0, rb}, rs, gq, gr, ge, ge ? 1 : 9);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
